// File: rtl/sparc_ifu_missreq_arb.sv
// sparc_ifu_missreq_arb
// Arbitrates the four IFU threads' instruction-miss requests onto the single
// shared outbound miss-request port. The winner's payload is registered and
// presented with a valid/ready handshake. Selection is round-robin from a park
// pointer (last accepted thread gets lowest priority), overridden by per-thread
// starvation age counters once a requester reaches AGE_LIMIT.
//
// Optional feature macro: IFU_MISSARB_STATS_EN
//   When defined, adds stat_conflict_cnt[15:0], a saturating count of loads
//   made while more than one thread was eligible.
module sparc_ifu_missreq_arb #(
  parameter int DW        = 40,
  parameter int AGE_W     = 4,
  parameter int AGE_LIMIT = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req_vec,
  input  logic [4*DW-1:0] req_data,
  input  logic [3:0]      flush_vec,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_tid,
  output logic [3:0]      gnt_ack
`ifdef IFU_MISSARB_STATS_EN
  ,
  output logic [15:0]     stat_conflict_cnt
`endif
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_LIMIT);
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       park_q;
  logic [AGE_W-1:0] age_q [4];

  logic             accept;
  logic [3:0]       elig;
  logic [3:0]       aged;
  logic             any_elig;
  logic             any_aged;
  logic [1:0]       aged_tid;
  logic [1:0]       rr_tid;
  logic [1:0]       win_tid;
  logic             load;
  logic [1:0]       rr_idx;

  // Handshake decode and eligibility of each thread for the next load.
  always_comb begin
    accept  = out_vld & out_rdy;
    gnt_ack = accept ? (4'b0001 << out_tid) : 4'b0000;
    // The thread accepted this cycle is excluded: its request drops next cycle.
    elig     = req_vec & ~flush_vec & ~gnt_ack;
    any_elig = |elig;
  end

  // Starvation override: lowest-index eligible thread whose age reached the limit.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it holding an old value and no latch is inferred.
    aged     = 4'b0000;
    aged_tid = 2'd0;
    for (int t = 3; t >= 0; t--) begin
      aged[t] = elig[t] && (age_q[t] >= AGE_LIM);
      if (aged[t]) aged_tid = 2'(t);
    end
    any_aged = |aged;
  end

  // Round-robin pick: search park+1, park+2, park+3, park; the earliest hit wins.
  always_comb begin
    rr_tid = 2'd0;
    rr_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      rr_idx = park_q + 2'(k) + 2'd1;
      if (elig[rr_idx]) rr_tid = rr_idx;
    end
    win_tid = any_aged ? aged_tid : rr_tid;
  end

  // Next-state logic: load from IDLE or back-to-back on an accept.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (accept) begin
          if (any_elig) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_vld = (state_q == PRESENT);

  // State, presented payload and park pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= IDLE;
      out_data <= '0;
      out_tid  <= 2'd0;
      park_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      if (accept) park_q <= out_tid;
      if (load) begin
        out_data <= req_data[32'(win_tid)*DW +: DW];
        out_tid  <= win_tid;
      end
    end
  end

  // Per-thread starvation age: grows on loads the thread loses, clears on ack or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the age array is only four small counters and must start at zero,
    // so it is reset like any other register rather than left uninitialised.
    if (!rst_n) begin
      for (int t = 0; t < 4; t++) age_q[t] <= '0;
    end else begin
      for (int t = 0; t < 4; t++) begin
        if (gnt_ack[t] || !req_vec[t]) begin
          age_q[t] <= '0;
        end else if (load && (win_tid != 2'(t)) && (age_q[t] != AGE_MAX)) begin
          age_q[t] <= age_q[t] + 1'b1;
        end
      end
    end
  end

`ifdef IFU_MISSARB_STATS_EN
  logic conflict;
  assign conflict = (elig & (elig - 4'd1)) != 4'b0000;

  // Saturating count of loads that had competing eligible threads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_conflict_cnt <= 16'h0000;
    end else if (load && conflict && (stat_conflict_cnt != 16'hFFFF)) begin
      stat_conflict_cnt <= stat_conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sparc_ifu_missreq_arb.sv
// Self-checking bench for sparc_ifu_missreq_arb. A cycle-level reference model
// predicts each load and pushes {tid, payload} into a scoreboard queue; a
// separate monitor pops and compares on every accepted handshake.
module tb_sparc_ifu_missreq_arb;

  localparam int DW      = 40;
  localparam int AGE_W   = 4;
  localparam int AGE_LIM = 3;

  typedef struct {
    int            tid;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [3:0]      req_vec;
  logic [4*DW-1:0] req_data;
  logic [3:0]      flush_vec;
  logic            out_vld;
  logic            out_rdy;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_tid;
  logic [3:0]      gnt_ack;
`ifdef IFU_MISSARB_STATS_EN
  logic [15:0]     stat_conflict_cnt;
`endif

  sparc_ifu_missreq_arb #(.DW(DW), .AGE_W(AGE_W), .AGE_LIMIT(AGE_LIM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_vec   (req_vec),
    .req_data  (req_data),
    .flush_vec (flush_vec),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_tid   (out_tid),
    .gnt_ack   (gnt_ack)
`ifdef IFU_MISSARB_STATS_EN
    ,
    .stat_conflict_cnt (stat_conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  exp_t          sb_q[$];
  logic [DW-1:0] tdata [4];

  // Reference model state
  bit m_vld;
  int m_tid;
  int m_park;
  int m_age [4];
  int m_conflicts;
  bit last_acc;
  int last_acc_tid;

  // Starvation observation (from DUT handshakes)
  bit starve_phase = 0;
  int run_others   = 0;
  int max_run      = 0;
  int grants3      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld       = 0;
    m_tid       = 0;
    m_park      = 3;
    m_conflicts = 0;
    for (int t = 0; t < 4; t++) m_age[t] = 0;
    sb_q.delete();
  endtask

  // One clock of the arbitration rules, evaluated on this cycle's inputs.
  task automatic model_step(input logic [3:0] r, input logic [3:0] f, input logic rdy);
    bit acc;
    bit el [4];
    int n;
    int win;
    bit ld;
    acc = m_vld && rdy;
    n   = 0;
    for (int t = 0; t < 4; t++) begin
      el[t] = r[t] && !f[t] && !(acc && t == m_tid);
      if (el[t]) n++;
    end
    ld  = (n > 0) && (!m_vld || acc);
    win = -1;
    for (int t = 0; t < 4; t++)
      if (win < 0 && el[t] && m_age[t] >= AGE_LIM) win = t;
    for (int k = 1; k <= 4; k++)
      if (win < 0 && el[(m_park + k) % 4]) win = (m_park + k) % 4;
    for (int t = 0; t < 4; t++) begin
      if ((acc && t == m_tid) || !r[t]) m_age[t] = 0;
      else if (ld && t != win && m_age[t] < (1 << AGE_W) - 1) m_age[t]++;
    end
    last_acc     = acc;
    last_acc_tid = m_tid;
    if (acc) m_park = m_tid;
    if (ld) begin
      exp_t e;
      e.tid  = win;
      e.data = tdata[win];
      sb_q.push_back(e);
      m_vld = 1;
      m_tid = win;
      if (n > 1 && m_conflicts < 16'hFFFF) m_conflicts++;
    end else if (acc) begin
      m_vld = 0;
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check handshake outputs, advance model.
  task automatic cycle(input logic [3:0] r, input logic [3:0] f, input logic rdy);
    logic [3:0] exp_gnt;
    @(negedge clk);
    req_vec   = r;
    flush_vec = f;
    out_rdy   = rdy;
    for (int t = 0; t < 4; t++) req_data[t*DW +: DW] = tdata[t];
    #1;
    exp_gnt = (m_vld && rdy) ? (4'b0001 << m_tid) : 4'b0000;
    check("out_vld", 64'(out_vld), 64'(m_vld));
    check("gnt_ack", 64'(gnt_ack), 64'(exp_gnt));
    model_step(r, f, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_vec   = 4'b0000;
    flush_vec = 4'b0000;
    out_rdy   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every accepted presentation must match the oldest prediction.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_vld && out_rdy) begin
        if (sb_q.size() == 0) begin
          check("accept_unexpected", 64'(out_tid), 64'hFFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_tid", 64'(out_tid), 64'(e.tid));
          check("sb_data", 64'(out_data), 64'(e.data));
        end
        if (starve_phase) begin
          if (out_tid == 2'd3) begin
            grants3++;
            run_others = 0;
          end else begin
            run_others++;
            if (run_others > max_run) max_run = run_others;
          end
        end
      end
    end
  end

  initial begin
    bit pend [4];
    logic [3:0] r;
    logic [3:0] f;

    rst_n     = 1'b0;
    req_vec   = 4'b0000;
    flush_vec = 4'b0000;
    out_rdy   = 1'b0;
    req_data  = '0;
    for (int t = 0; t < 4; t++) tdata[t] = DW'(64'h10_0000_0000 * (t + 1) + 64'h123);
    model_reset();
    #3;
    check("rst_out_vld", 64'(out_vld), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_tid", 64'(out_tid), 64'h0);
    check("rst_gnt_ack", 64'(gnt_ack), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single request on thread 2, accepted one cycle after the load, then dropped.
    cycle(4'b0100, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b1);
    check("single_tid", 64'(out_tid), 64'h2);
    cycle(4'b0000, 4'b0000, 1'b1);

    // Round-robin with everyone requesting and the port always ready.
    do_reset();
    repeat (8) cycle(4'b1111, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);

    // Backpressure on a thread-1 presentation while its payload changes and it is flushed.
    do_reset();
    cycle(4'b0010, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tdata[1] = ~tdata[1];
      cycle(4'b0010, 4'b0010, 1'b0);
      check("bp_tid_hold", 64'(out_tid), 64'h1);
    end
    cycle(4'b0010, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);

    // Starvation: all threads keep requesting, port ready every other cycle.
    do_reset();
    starve_phase = 1;
    for (int i = 0; i < 40; i++) cycle(4'b1111, 4'b0000, 1'(i % 2));
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);
    starve_phase = 0;
    check("starve_thread3_granted", 64'(grants3 > 0), 64'h1);
    check("starve_run_bound", 64'(max_run <= AGE_LIM + 1), 64'h1);

    // Flush blocks thread 3; park moves to 0 and holds through an idle stretch.
    do_reset();
    cycle(4'b0100, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b1);
    cycle(4'b1001, 4'b1000, 1'b1);
    cycle(4'b1001, 4'b1000, 1'b1);
    check("flush_pick_tid0", 64'(out_tid), 64'h0);
    repeat (10) cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b1);
    check("park_hold_tid1", 64'(out_tid), 64'h1);
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);

    // Asynchronous reset while a presentation is pending.
    do_reset();
    cycle(4'b1111, 4'b0000, 1'b0);
    @(negedge clk);
    #1;
    check("pre_reset_vld", 64'(out_vld), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_vld", 64'(out_vld), 64'h0);
    check("async_rst_tid", 64'(out_tid), 64'h0);
    model_reset();
    req_vec = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b1);
    check("post_reset_first_tid0", 64'(out_tid), 64'h0);
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);

    // Randomized traffic obeying the hold-until-ack request protocol.
    do_reset();
    for (int t = 0; t < 4; t++) pend[t] = 0;
    for (int i = 0; i < 600; i++) begin
      for (int t = 0; t < 4; t++) begin
        if (!pend[t] && $urandom_range(0, 2) == 0) begin
          pend[t]  = 1;
          tdata[t] = DW'({$urandom(), $urandom()});
        end
      end
      for (int t = 0; t < 4; t++) begin
        r[t] = pend[t];
        f[t] = ($urandom_range(0, 7) == 0);
      end
      cycle(r, f, ($urandom_range(0, 3) != 0));
      if (last_acc) pend[last_acc_tid] = 0;
    end
    repeat (4) cycle(4'b0000, 4'b0000, 1'b1);
    check("sb_drained", 64'(sb_q.size()), 64'h0);
`ifdef IFU_MISSARB_STATS_EN
    check("stat_conflict_cnt", 64'(stat_conflict_cnt), 64'(m_conflicts));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sparc_ifu_missreq_arb.md
Name: sparc_ifu_missreq_arb

Overview:
- Arbitrates the four IFU threads' instruction-miss requests onto the single shared outbound miss-request port toward the L1.5/L2 interface.
- Registers the winning thread's payload and presents it with a valid/ready handshake.
- Round-robin: the last-accepted thread gets lowest priority. A per-thread age counter forces service of any thread starved past a threshold.
- Sits between the per-thread miss buffers and the shared request port, after the thread-select logic.

Parameters:
DW, 40, request payload width per thread (physical address plus attributes)
AGE_W, 4, width of each per-thread starvation age counter
AGE_LIMIT, 12, age at which a requester is forced ahead of round-robin order; must be < 2^AGE_W

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
req_vec  input  4  per-thread request level; held high until that thread's gnt_ack
req_data  input  4*DW  per-thread payload; thread t occupies bits [t*DW +: DW]; stable while req_vec[t]=1
flush_vec  input  4  per-thread cancel; a flushed thread is ineligible this cycle
out_vld  output  1  payload valid on the shared port
out_rdy  input  1  downstream accepts when out_vld & out_rdy
out_data  output  DW  registered payload of the presented thread
out_tid  output  2  thread id of the presented payload
gnt_ack  output  4  one-hot pulse to the accepted thread (combinational: out_vld & out_rdy decoded by out_tid)

Behaviour:
- Reset (async, rst_n=0):
  - out_vld=0, out_data=0, out_tid=0, gnt_ack=0.
  - FSM=IDLE, park pointer = thread 3, so thread 0 has first priority.
  - All age counters = 0.
- Eligibility: elig[t] = req_vec[t] & ~flush_vec[t] & ~(accept_this_cycle & out_tid==t). The thread just accepted is excluded because its request drops next cycle.
- Selection, combinational, one-hot winner:
  - If any eligible thread has age >= AGE_LIMIT, pick the lowest index among those.
  - Otherwise round-robin starting at park+1 mod 4 and wrapping: with park=p, priority order is p+1, p+2, p+3, p.
  - With no eligible thread, nothing is loaded and park is unchanged.
- FSM states IDLE and PRESENT:
  - IDLE: if any thread is eligible, load out_data/out_tid from the winner and go to PRESENT (out_vld=1 next cycle). Latency from req_vec rise to out_vld is 1 cycle.
  - PRESENT with out_rdy=0: out_data/out_tid/out_vld held stable. No retraction, even if flush_vec[out_tid] rises; downstream drops flushed returns.
  - PRESENT with out_rdy=1: gnt_ack[out_tid]=1 this cycle and park <= out_tid.
    - If another thread is eligible, load the winner in the same cycle and stay in PRESENT (back-to-back, no bubble).
    - Otherwise go to IDLE, out_vld=0.
- Age counters: age[t] increments (saturating at 2^AGE_W-1) on each cycle where a load occurs, req_vec[t]=1, and t is not the winner. It clears when gnt_ack[t] fires or req_vec[t]=0.
- Simultaneous events:
  - Flush and request in the same cycle: flush wins, thread ineligible.
  - Two threads at the age limit: lower index wins, the other keeps its age and wins the next load.
- Reset mid-handshake: an unaccepted presentation is discarded; requesters must re-present after reset.

Optional Feature:
- Macro IFU_MISSARB_STATS_EN.
- Defined: adds output stat_conflict_cnt[15:0]. It increments on each load with more than one eligible thread, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counter absent; arbitration behaviour identical.

Test Plan:
- Single request: after reset, req_vec=4'b0100 and out_rdy=1.
  - out_vld=1 with out_tid=2 one cycle later; gnt_ack=4'b0100 that cycle.
  - Drop req: out_vld=0 next cycle.
- Round-robin: req_vec=4'b1111 held, out_rdy=1 constantly.
  - out_tid sequence 0,1,2,3,0 on consecutive cycles, no bubbles; gnt_ack one-hot each cycle.
- Backpressure: present tid=1 and hold out_rdy=0 for 5 cycles while toggling req_data[1] and asserting flush_vec[1].
  - out_data/out_tid stay constant, out_vld stays 1, no gnt_ack until out_rdy=1.
- Starvation, with AGE_LIMIT=3:
  - Setup: thread 3 requests continuously; threads 0-2 re-request immediately after each ack; out_rdy pulses every other cycle.
  - Thread 3 is granted no later than its 4th losing load; its age clears after ack.
- Flush and park hold:
  - park=2, req_vec=4'b1001, flush_vec=4'b1000: out_tid=0.
  - Then no requests for 10 cycles: park stays 0, and the next all-request load picks thread 1.
- Async reset asserted while out_vld=1: out_vld drops immediately with no clock edge; after release, req_vec=4'b1111 grants thread 0 first.
